// File: rtl/set_max_delay.sv
// set_max_delay: max-delay benchmark netlist.
// u1 deserialises port1 into a word and hands it to u2 over a four-phase
// req/ack handshake. u2 runs the word through a long combinational
// rotate/increment chain and registers the result on port2.
// Optional build macro: SET_MAX_DELAY_PIPE_EN splits the u2 chain with a
// register at its midpoint, so every response arrives one cycle later.

// u1: serial-to-parallel launcher with four-phase request side
module set_max_delay_launch #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit,
  input  logic             i_bit_en,
  input  logic             i_ack,
  output logic             o_rdy_c,
  output logic [WIDTH-1:0] o_data,
  output logic             o_req
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_SHIFT        = 2'd0,
    S_REQ          = 2'd1,
    S_WAIT_ACK_LOW = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req;

  // Ready is a pure decode of the state register
  assign o_rdy_c = (r_state == S_SHIFT);
  assign o_data  = r_sr;
  assign o_req   = r_req;

  // Shift bits in MSB first, then hold the word while the handshake runs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_SHIFT;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (i_bit_en) begin
            r_sr <= {r_sr[WIDTH-2:0], i_bit};
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_REQ: begin
          if (i_ack) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT_ACK_LOW;
          end
        end
        S_WAIT_ACK_LOW: begin
          if (!i_ack) begin
            r_state <= S_SHIFT;
          end
        end
        default: begin
          r_state <= S_SHIFT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// u2: mixing-chain responder with four-phase acknowledge side
module set_max_delay_capture #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHAIN_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_req,
  output logic             o_ack,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid
);

  localparam int unsigned HALF = CHAIN_DEPTH / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] w_mid;
  logic [WIDTH-1:0] w_tail_in;
  logic [WIDTH-1:0] w_res;

  // One mixing stage: rotate left by one, then add one (carry dropped)
  function automatic logic [WIDTH-1:0] f_stage(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]} + WIDTH'(1);
  endfunction

  // First half of the chain, straight from the launched word
  always_comb begin
    w_mid = i_data;
    for (int unsigned i = 0; i < HALF; i++) begin
      w_mid = f_stage(w_mid);
    end
  end

`ifdef SET_MAX_DELAY_PIPE_EN
  logic [WIDTH-1:0] r_half;
  assign w_tail_in = r_half;
`else
  assign w_tail_in = w_mid;
`endif

  // Second half of the chain, fed by the midpoint (registered or not)
  always_comb begin
    w_res = w_tail_in;
    for (int unsigned i = HALF; i < CHAIN_DEPTH; i++) begin
      w_res = f_stage(w_res);
    end
  end

  // Responder: capture on request, pulse valid once, release ack after req drops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      o_ack    <= 1'b0;
      o_result <= '0;
      o_valid  <= 1'b0;
`ifdef SET_MAX_DELAY_PIPE_EN
      r_half   <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
`ifdef SET_MAX_DELAY_PIPE_EN
            r_half  <= w_mid;
            r_state <= S_CALC;
`else
            o_result <= w_res;
            o_valid  <= 1'b1;
            o_ack    <= 1'b1;
            r_state  <= S_ACK;
`endif
          end
        end
`ifdef SET_MAX_DELAY_PIPE_EN
        S_CALC: begin
          o_result <= w_res;
          o_valid  <= 1'b1;
          o_ack    <= 1'b1;
          r_state  <= S_ACK;
        end
`endif
        S_ACK: begin
          if (!i_req) begin
            o_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          o_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// Top: u1 launch -> u2 capture, through-object nets named for the constraints
module set_max_delay #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHAIN_DEPTH = 4
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             port1,
  input  logic             port1_en,
  output logic             port1_rdy,
  output logic [WIDTH-1:0] port2,
  output logic             port2_valid
);

  logic [WIDTH-1:0] net1_data;
  logic             net1_req;
  logic             net2_ack;

  set_max_delay_launch #(
    .WIDTH (WIDTH)
  ) u1 (
    .i_clk    (clk1),
    .i_rst    (rst),
    .i_bit    (port1),
    .i_bit_en (port1_en),
    .i_ack    (net2_ack),
    .o_rdy_c  (port1_rdy),
    .o_data   (net1_data),
    .o_req    (net1_req)
  );

  set_max_delay_capture #(
    .WIDTH       (WIDTH),
    .CHAIN_DEPTH (CHAIN_DEPTH)
  ) u2 (
    .i_clk    (clk1),
    .i_rst    (rst),
    .i_data   (net1_data),
    .i_req    (net1_req),
    .o_ack    (net2_ack),
    .o_result (port2),
    .o_valid  (port2_valid)
  );

endmodule

// File: tb/tb_set_max_delay.sv
// Bench for set_max_delay (WIDTH=8, CHAIN_DEPTH=4): table of words with
// hand-computed mixed results plus handshake, streaming and reset sequences.
module tb_set_max_delay;

`ifdef SET_MAX_DELAY_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int W = 8;

  logic         clk1 = 1'b0;
  logic         rst;
  logic         port1;
  logic         port1_en;
  logic         port1_rdy;
  logic [W-1:0] port2;
  logic         port2_valid;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;

  set_max_delay #(.WIDTH(W), .CHAIN_DEPTH(4)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .port1       (port1),
    .port1_en    (port1_en),
    .port1_rdy   (port1_rdy),
    .port2       (port2),
    .port2_valid (port2_valid)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) if (port2_valid === 1'b1) n_valid <= n_valid + 1;

  typedef struct {
    logic [7:0] word;
    bit         gapped;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 20 && port1_rdy !== 1'b1; i++) step();
    if (port1_rdy !== 1'b1) chk("rdy_timeout", {31'd0, port1_rdy}, 32'd1);
  endtask

  // Send nbits of word, MSB first; optional idle cycles with garbage bits between
  task automatic send_bits(input logic [7:0] word, input int nbits, input bit gapped);
    for (int k = 0; k < nbits; k++) begin
      if (gapped && k > 0) begin
        port1_en = 1'b0;
        port1    = ~port1;
        step();
      end
      wait_rdy();
      port1_en = 1'b1;
      port1    = word[7-k];
      step();
    end
    port1_en = 1'b0;
  endtask

  // From just after E0: check the full four-phase sequence and the result
  task automatic handshake(input string tag, input logic [7:0] word, input logic [7:0] exp);
    chk({tag, "_data"}, 32'(dut.net1_data), 32'(word));
    chk({tag, "_req_e0"}, 32'(dut.net1_req), 32'd1);
    chk({tag, "_rdy_e0"}, 32'(port1_rdy), 32'd0);
    chk({tag, "_valid_e0"}, 32'(port2_valid), 32'd0);
    for (int e = 1; e <= LAT + 3; e++) begin
      step();
      if (e < LAT) begin
        chk({tag, "_ack_calc"}, 32'(dut.net2_ack), 32'd0);
        chk({tag, "_valid_calc"}, 32'(port2_valid), 32'd0);
      end else if (e == LAT) begin
        chk({tag, "_port2"}, 32'(port2), 32'(exp));
        chk({tag, "_valid"}, 32'(port2_valid), 32'd1);
        chk({tag, "_ack_rise"}, 32'(dut.net2_ack), 32'd1);
        chk({tag, "_req_hold"}, 32'(dut.net1_req), 32'd1);
      end else if (e == LAT + 1) begin
        chk({tag, "_req_fall"}, 32'(dut.net1_req), 32'd0);
        chk({tag, "_valid_pulse"}, 32'(port2_valid), 32'd0);
        chk({tag, "_ack_hold"}, 32'(dut.net2_ack), 32'd1);
      end else if (e == LAT + 2) begin
        chk({tag, "_ack_fall"}, 32'(dut.net2_ack), 32'd0);
        chk({tag, "_rdy_low"}, 32'(port1_rdy), 32'd0);
        chk({tag, "_port2_hold"}, 32'(port2), 32'(exp));
      end else begin
        chk({tag, "_rdy_back"}, 32'(port1_rdy), 32'd1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, v0;
    logic [7:0] pv;

    vecs[0] = '{8'h81, 1'b0, 8'h27};
    vecs[1] = '{8'h00, 1'b0, 8'h0F};
    vecs[2] = '{8'hFF, 1'b0, 8'h07};
    vecs[3] = '{8'h5A, 1'b0, 8'hB4};
    vecs[4] = '{8'h80, 1'b0, 8'h17};
    vecs[5] = '{8'h7F, 1'b0, 8'h03};
    vecs[6] = '{8'h81, 1'b1, 8'h27};
    vecs[7] = '{8'h5A, 1'b1, 8'hB4};

    // Reset state
    port1 = 1'b0; port1_en = 1'b0; rst = 1'b1;
    #12;
    chk("rst_port2", 32'(port2), 32'd0);
    chk("rst_valid", 32'(port2_valid), 32'd0);
    chk("rst_rdy", 32'(port1_rdy), 32'd1);
    chk("rst_req", 32'(dut.net1_req), 32'd0);
    chk("rst_ack", 32'(dut.net2_ack), 32'd0);
    @(negedge clk1);
    rst = 1'b0;
    step();

    // Table of words, contiguous and gapped
    foreach (vecs[i]) begin
      send_bits(vecs[i].word, 8, vecs[i].gapped);
      handshake($sformatf("vec%0d", i), vecs[i].word, vecs[i].exp);
    end

    // Continuous port1_en=1 with port1=1: extra bits dropped, fixed spacing
    p0 = -1; p1 = -1; pv = 8'h00;
    port1_en = 1'b1; port1 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (port2_valid === 1'b1) begin
        if (p0 < 0) begin
          p0 = c;
          pv = port2;
        end else if (p1 < 0) p1 = c;
      end
    end
    port1_en = 1'b0;
    chk("stream_port2", 32'(pv), 32'h07);
    chk("stream_spacing", 32'(p1 - p0), 32'(W + 3 + LAT));
    wait_rdy();

    // Asynchronous reset mid-handshake, checked before any clock edge
    send_bits(8'h81, 8, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_port2", 32'(port2), 32'd0);
    chk("arst_valid", 32'(port2_valid), 32'd0);
    chk("arst_rdy", 32'(port1_rdy), 32'd1);
    chk("arst_req", 32'(dut.net1_req), 32'd0);
    @(negedge clk1);
    rst = 1'b0;
    step();

    // Reset after 5 of 8 bits discards the partial word
    send_bits(8'hAA, 5, 1'b0);
    @(negedge clk1);
    rst = 1'b1;
    #2 rst = 1'b0;
    v0 = n_valid;
    send_bits(8'h81, 8, 1'b0);
    for (int c = 0; c < 12; c++) step();
    chk("partial_pulses", 32'(n_valid - v0), 32'd1);
    chk("partial_port2", 32'(port2), 32'h27);
    chk("partial_rdy", 32'(port1_rdy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
